// File: rtl/jk_pkg.sv
// Shared definitions for the JK-flop counter: mode encodings and the
// per-bit J/K excitation helper.
package jk_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef struct packed {
      logic j;
      logic k;
   } jk_t;

   // Set only on a 0->1 change, reset only on 1->0; toggle is never requested.
   function automatic jk_t jk_excite(input logic cur, input logic nxt);
      jk_t r;
      r.j = ~cur & nxt;
      r.k = cur & ~nxt;
      return r;
   endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Single JK flip-flop with asynchronous active-high clear.
module jk_ff_ar (
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
         endcase
      end
   end

endmodule

// File: rtl/jk_counter.sv
// Modulo-N up/down counter whose state lives in a bank of JK flops; the
// binary next state is translated into per-bit J/K excitation.
module jk_counter
   import jk_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             wrap,
   output logic             load_err
);

   if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
      $fatal(1, "jk_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
   end

   // One extra bit so MODULUS itself is representable when MODULUS == 2**WIDTH.
   localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   next_ext;
   logic [WIDTH-1:0] next_q;
   logic             wrap_next;
   logic             load_err_next;
   logic [WIDTH-1:0] j_bits;
   logic [WIDTH-1:0] k_bits;

   assign q_ext  = {1'b0, q};
   assign d_ext  = {1'b0, d};
   assign next_q = next_ext[WIDTH-1:0];

   always_comb begin
      next_ext      = q_ext;
      wrap_next     = 1'b0;
      load_err_next = 1'b0;
      if (en) begin
         case (mode)
            MODE_UP: begin
               // >= also folds any out-of-range state back to 0.
               if (q_ext >= MAX_EXT) begin
                  next_ext  = '0;
                  wrap_next = 1'b1;
               end else begin
                  next_ext = q_ext + ONE_EXT;
               end
            end
            MODE_DOWN: begin
               if (q_ext == '0) begin
                  next_ext  = MAX_EXT;
                  wrap_next = 1'b1;
               end else begin
                  next_ext = q_ext - ONE_EXT;
               end
            end
            MODE_LOAD: begin
               if (d_ext < MOD_EXT) begin
                  next_ext = d_ext;
               end else begin
                  next_ext      = MAX_EXT;
                  load_err_next = 1'b1;
               end
            end
            default: next_ext = q_ext;
         endcase
      end
   end

   always_comb begin
      j_bits = '0;
      k_bits = '0;
      for (int i = 0; i < WIDTH; i++) begin
         {j_bits[i], k_bits[i]} = jk_excite(q[i], next_q[i]);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff_ar u_ff (
         .clk (clk),
         .rst (rst),
         .j   (j_bits[i]),
         .k   (k_bits[i]),
         .q   (q[i])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= wrap_next;
         load_err <= load_err_next;
      end
   end

endmodule

// File: tb/tb_jk_counter.sv
// Self-checking bench: directed scenarios plus random traffic on a
// modulo-10 and a full-range modulo-8 counter against an arithmetic model.
module tb_jk_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_a = 1'b0, en_b = 1'b0;
   logic [1:0] mode_a = 2'b00, mode_b = 2'b00;
   logic [3:0] d_a = '0;
   logic [2:0] d_b = '0;
   logic [3:0] q_a;
   logic [2:0] q_b;
   logic       wrap_a, wrap_b, err_a, err_b;

   int total = 0;
   int passed = 0;
   int mq_a = 0, mq_b = 0;
   logic mw_a = 0, mw_b = 0, me_a = 0, me_b = 0;

   always #5 clk = ~clk;

   jk_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .d(d_a),
      .q(q_a), .wrap(wrap_a), .load_err(err_a));

   jk_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .d(d_b),
      .q(q_b), .wrap(wrap_b), .load_err(err_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void model(input int m, input logic e, input logic [1:0] md,
                                 input int dv, inout int mq, output logic w, output logic er);
      w = 0; er = 0;
      if (e && md == 2'b01) begin
         if (mq == m - 1) begin mq = 0; w = 1; end else mq = mq + 1;
      end else if (e && md == 2'b10) begin
         if (mq == 0) begin mq = m - 1; w = 1; end else mq = mq - 1;
      end else if (e && md == 2'b11) begin
         if (dv < m) mq = dv; else begin mq = m - 1; er = 1; end
      end
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".q_a"}, 32'(q_a), 32'(mq_a));
      check({tag, ".wrap_a"}, 32'(wrap_a), 32'(mw_a));
      check({tag, ".err_a"}, 32'(err_a), 32'(me_a));
      check({tag, ".q_b"}, 32'(q_b), 32'(mq_b));
      check({tag, ".wrap_b"}, 32'(wrap_b), 32'(mw_b));
      check({tag, ".err_b"}, 32'(err_b), 32'(me_b));
      check({tag, ".jk_a"}, 32'(dut_a.j_bits & dut_a.k_bits), 32'd0);
      check({tag, ".jk_b"}, 32'(dut_b.j_bits & dut_b.k_bits), 32'd0);
   endtask

   task automatic tick(input string tag, input logic ea, input logic [1:0] ma, input logic [3:0] da,
                       input logic eb, input logic [1:0] mb, input logic [2:0] db);
      en_a = ea; mode_a = ma; d_a = da;
      en_b = eb; mode_b = mb; d_b = db;
      @(posedge clk);
      #1;
      model(10, ea, ma, int'(da), mq_a, mw_a, me_a);
      model(8, eb, mb, int'(db), mq_b, mw_b, me_b);
      check_all(tag);
   endtask

   task automatic tick_a(input string tag, input logic ea, input logic [1:0] ma, input logic [3:0] da);
      tick(tag, ea, ma, da, 1'b0, 2'b00, 3'd0);
   endtask

   initial begin
      #12;
      check_all("reset");
      rst = 1'b0;

      // Reset mid-count, away from the clock edge
      tick_a("ld7", 1, 2'b11, 4'd7);
      #2 rst = 1'b1;
      #1;
      mq_a = 0; mw_a = 0; me_a = 0; mq_b = 0; mw_b = 0; me_b = 0;
      check_all("async_rst");
      #1 rst = 1'b0;
      tick_a("up_after_rst", 1, 2'b01, 4'd0);
      check("first_up_q", 32'(q_a), 32'd1);

      // Up wrap from 0 over 12 edges
      tick_a("ld0", 1, 2'b11, 4'd0);
      for (int i = 0; i < 12; i++) tick_a("up", 1, 2'b01, 4'($urandom_range(0, 15)));

      // Down wrap from 2
      tick_a("ld2", 1, 2'b11, 4'd2);
      for (int i = 0; i < 4; i++) tick_a("down", 1, 2'b10, 4'd0);

      // Load range handling
      tick_a("ld5", 1, 2'b11, 4'd5);
      tick_a("ld12", 1, 2'b11, 4'd12);
      check("ld12_sat", 32'(q_a), 32'd9);
      check("ld12_err", 32'(err_a), 32'd1);
      tick_a("up_after_sat", 1, 2'b01, 4'd0);
      check("sat_wrap", 32'(wrap_a), 32'd1);
      tick_a("ld15", 1, 2'b11, 4'd15);

      // Hold via en=0 and via mode=00
      tick_a("ld3", 1, 2'b11, 4'd3);
      for (int i = 0; i < 5; i++) tick_a("en_off", 0, 2'b01, 4'd0);
      for (int i = 0; i < 5; i++) tick_a("mode_hold", 1, 2'b00, 4'd0);
      check("hold_q", 32'(q_a), 32'd3);

      // Full-range counter: wrap from 7 with explicit compare
      tick("b_ld7", 0, 2'b00, 4'd0, 1, 2'b11, 3'd7);
      tick("b_up7", 0, 2'b00, 4'd0, 1, 2'b01, 3'd0);
      check("b_wrap_q", 32'(q_b), 32'd0);
      check("b_wrap", 32'(wrap_b), 32'd1);

      // Random traffic on both counters
      for (int i = 0; i < 100; i++) begin
         tick("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
              1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
